// File: rtl/control_word_executor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : control_word_executor                                        |
// | Description : Executes one 13-bit control word per transaction: reads two  |
// |               operands from a 4-entry register file, runs the ALU, then     |
// |               writes back register / FLAGS {N,V,C,Z} / DOUT and pulses DONE.|
// | Options     : CWE_SATURATE_EN - signed saturation on ADD/SUB overflow.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module control_word_executor #(
  parameter int DATA_W = 8
) (
  input  logic              CLK_MASTER,
  input  logic              RST_MASTER_N,
  input  logic [12:0]       CW,
  input  logic              CW_VALID,
  output logic              CW_READY,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic [3:0]        FLAGS,
  output logic              DONE
);

  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

`ifdef CWE_SATURATE_EN
  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [12:0]       cw_q, cw_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [3:0]        nflags_q, nflags_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [3:0]        flags_q, flags_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];

  // Captured control-word fields; the live CW input is never used past capture.
  logic       we, use_din, flags_en, out_en;
  logic [1:0] dst, srca, srcb;
  logic [2:0] aluop;
  assign we       = cw_q[12];
  assign dst      = cw_q[11:10];
  assign srca     = cw_q[9:8];
  assign srcb     = cw_q[7:6];
  assign aluop    = cw_q[5:3];
  assign use_din  = cw_q[2];
  assign flags_en = cw_q[1];
  assign out_en   = cw_q[0];

  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] alu_res, exec_res;
  logic              alu_c, alu_v, exec_c, exec_v;
  logic [3:0]        exec_flags;

  // ALU on the latched operands, result selection and flag generation.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    alu_res = a_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (aluop)
      OP_PASS: alu_res = a_q;
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        // Carry is the inverse of borrow, so C=1 means A >= B unsigned.
        alu_res = diff[DATA_W-1:0];
        alu_c   = ~diff[DATA_W];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = {a_q[MSB-1:0], 1'b0};
        alu_c   = a_q[MSB];
      end
      OP_NOT:  alu_res = ~a_q;
    endcase
`ifdef CWE_SATURATE_EN
    // Overflow direction always follows the sign of A for both ADD and SUB.
    if (((aluop == OP_ADD) || (aluop == OP_SUB)) && alu_v)
      alu_res = a_q[MSB] ? SAT_NEG : SAT_POS;
`endif
    if (use_din) begin
      exec_res = din_q;
      exec_c   = 1'b0;
      exec_v   = 1'b0;
    end else begin
      exec_res = alu_res;
      exec_c   = alu_c;
      exec_v   = alu_v;
    end
    exec_flags = {exec_res[MSB], exec_v, exec_c, (exec_res == '0)};
  end

  // Sequencer and datapath next-state: capture, read, execute, write back.
  always_comb begin
    state_d  = state_q;
    cw_d     = cw_q;
    din_d    = din_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    nflags_d = nflags_q;
    regs_d   = regs_q;
    dout_d   = dout_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    CW_READY = 1'b0;
    case (state_q)
      S_IDLE: begin
        CW_READY = 1'b1;
        if (CW_VALID) begin
          cw_d    = CW;
          din_d   = DIN;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = regs_q[srca];
        b_d     = regs_q[srcb];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d    = exec_res;
        nflags_d = exec_flags;
        state_d  = S_WB;
      end
      S_WB: begin
        if (we)       regs_d[dst] = res_q;
        if (flags_en) flags_d     = nflags_q;
        if (out_en)   dout_d      = res_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight word.
  always_ff @(posedge CLK_MASTER or negedge RST_MASTER_N) begin
    if (!RST_MASTER_N) begin
      state_q  <= S_IDLE;
      cw_q     <= '0;
      din_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      nflags_q <= '0;
      dout_q   <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cw_q     <= cw_d;
      din_q    <= din_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      nflags_q <= nflags_d;
      dout_q   <= dout_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign DOUT  = dout_q;
  assign FLAGS = flags_q;
  assign DONE  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_control_word_executor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_control_word_executor                                     |
// | Description : Scoreboard bench: driver pushes expected DOUT/FLAGS/DONE time |
// |               from a reference model; a monitor pops on every DONE.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_control_word_executor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [12:0]  cw = '0;
  logic         cw_valid = 1'b0;
  logic         cw_ready;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic [3:0]   flags;
  logic         done;

  always #5 clk = ~clk;

  control_word_executor #(.DATA_W(W)) dut (
    .CLK_MASTER   (clk),
    .RST_MASTER_N (rst_n),
    .CW           (cw),
    .CW_VALID     (cw_valid),
    .CW_READY     (cw_ready),
    .DIN          (din),
    .DOUT         (dout),
    .FLAGS        (flags),
    .DONE         (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] dout;
    logic [3:0]   flags;
    int           done_cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mr [4];
  logic [W-1:0] m_dout;
  logic [3:0]   m_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] mk(input logic we, input logic [1:0] dst, input logic [1:0] sa,
                                     input logic [1:0] sbv, input logic [2:0] op,
                                     input logic ud, input logic fe, input logic oe);
    return {we, dst, sa, sbv, op, ud, fe, oe};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mr[i] = '0;
    m_dout  = '0;
    m_flags = '0;
    sb.delete();
  endtask

  // Reference model: integer arithmetic straight from the operation table.
  task automatic model_push(input logic [12:0] w, input logic [W-1:0] d, input int acc);
    int a, b, sa, sbs, r, sr;
    logic c, v;
    logic [W-1:0] res;
    exp_t e;
    a  = int'(mr[w[9:8]]);
    b  = int'(mr[w[7:6]]);
    sa  = (a >= 2**(W-1)) ? a - 2**W : a;
    sbs = (b >= 2**(W-1)) ? b - 2**W : b;
    c = 1'b0; v = 1'b0; sr = 0; r = 0;
    case (w[5:3])
      3'd0: r = a;
      3'd1: begin r = a + b; c = (r >= 2**W); sr = sa + sbs; v = (sr > 2**(W-1)-1) || (sr < -(2**(W-1))); end
      3'd2: begin r = a - b; c = (a >= b);    sr = sa - sbs; v = (sr > 2**(W-1)-1) || (sr < -(2**(W-1))); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin r = a * 2; c = (a >= 2**(W-1)); end
      3'd7: r = (2**W - 1) - a;
    endcase
    res = r[W-1:0];
`ifdef CWE_SATURATE_EN
    if (v) begin
      sr  = (sr > 0) ? 2**(W-1) - 1 : 2**(W-1);
      res = sr[W-1:0];
    end
`endif
    if (w[2]) begin res = d; c = 1'b0; v = 1'b0; end
    if (w[12]) mr[w[11:10]] = res;
    if (w[1])  m_flags = {res[W-1], v, c, (res == '0)};
    if (w[0])  m_dout  = res;
    e.dout = m_dout; e.flags = m_flags; e.done_cyc = acc + 3;
    sb.push_back(e);
  endtask

  // Monitor: every DONE pulse consumes one expected transaction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected DONE: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("DOUT", 32'(dout), 32'(e.dout));
        check("FLAGS", 32'(flags), 32'(e.flags));
        check("DONE latency", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // Driver: junk (possibly with VALID) while busy, real word once READY is seen.
  task automatic send(input logic [12:0] w, input logic [W-1:0] d, output int acc);
    int n = 0;
    acc = -1;
    @(negedge clk);
    while (!cw_ready) begin
      cw       = 13'($urandom);
      din      = W'($urandom);
      cw_valid = 1'($urandom);
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL handshake timeout: got CW_READY=0 expected 1 within 20 cycles");
        return;
      end
      @(negedge clk);
    end
    cw = w; din = d; cw_valid = 1'b1;
    acc = cyc + 1;
    model_push(w, d, acc);
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    cw_valid = 1'b0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc1, acc2;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset DOUT", 32'(dout), 32'd0);
    check("reset FLAGS", 32'(flags), 32'd0);
    check("reset DONE", 32'(done), 32'd0);
    check("reset CW_READY", 32'(cw_ready), 32'd1);
    rst_n = 1'b1;

    // Load R1 from DIN with all enables.
    send(mk(1'b1, 2'd1, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1), 8'h5A, acc1);
    drain();
    check("load DOUT", 32'(dout), 32'h5A);
    check("load FLAGS", 32'(flags), 32'h0);

    // Add with carry out: FF + 01.
    send(mk(1'b1, 2'd1, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0), 8'hFF, acc1);
    send(mk(1'b1, 2'd2, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0), 8'h01, acc1);
    send(mk(1'b1, 2'd3, 2'd1, 2'd2, 3'd1, 1'b0, 1'b1, 1'b1), 8'h00, acc1);
    drain();
    check("add carry DOUT", 32'(dout), 32'h00);
    check("add carry FLAGS", 32'(flags), 32'b0011);

    // Signed overflow: 7F + 01.
    send(mk(1'b1, 2'd1, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0), 8'h7F, acc1);
    send(mk(1'b1, 2'd3, 2'd1, 2'd2, 3'd1, 1'b0, 1'b1, 1'b1), 8'h00, acc1);
    drain();
`ifdef CWE_SATURATE_EN
    check("overflow DOUT", 32'(dout), 32'h7F);
    check("overflow FLAGS", 32'(flags), 32'b0100);
`else
    check("overflow DOUT", 32'(dout), 32'h80);
    check("overflow FLAGS", 32'(flags), 32'b1100);
`endif

    // Back-to-back with a read-after-write dependency through R0.
    send(mk(1'b1, 2'd0, 2'd1, 2'd2, 3'd1, 1'b0, 1'b0, 1'b0), 8'h00, acc1);
    send(mk(1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1), 8'h00, acc2);
    check("back-to-back spacing", 32'(acc2 - acc1), 32'd4);
    drain();
`ifdef CWE_SATURATE_EN
    check("dependent DOUT", 32'(dout), 32'h7F);
`else
    check("dependent DOUT", 32'(dout), 32'h80);
`endif

    // FLAGS_EN=0 keeps the previous flags; NOP still pulses DONE.
    send(mk(1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b1), 8'h3C, acc1);
    send(mk(1'b0, 2'd2, 2'd1, 2'd3, 3'd2, 1'b0, 1'b0, 1'b0), 8'hEE, acc1);
    drain();
    check("no-flags DOUT", 32'(dout), 32'h3C);
`ifdef CWE_SATURATE_EN
    check("no-flags FLAGS", 32'(flags), 32'b0100);
`else
    check("no-flags FLAGS", 32'(flags), 32'b1100);
`endif

    // Reset while the word is in EXEC: the write of R2 must not land.
    send(mk(1'b1, 2'd2, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1), 8'hAB, acc1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    cw_valid = 1'b0;
    model_reset();
    #1;
    check("mid-reset DOUT", 32'(dout), 32'd0);
    check("mid-reset FLAGS", 32'(flags), 32'd0);
    check("mid-reset DONE", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after release", 32'(cw_ready), 32'd1);
    send(mk(1'b0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b1, 1'b1), 8'h00, acc1);
    drain();
    check("post-reset R2 DOUT", 32'(dout), 32'h00);
    check("post-reset R2 FLAGS", 32'(flags), 32'b0001);

    // Randomized words with random idle gaps.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        cw_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      send(13'($urandom), W'($urandom), acc1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
